// File: rtl/ecc_point_unit_pkg.sv
// ecc_point_unit_pkg
//   Shared definitions for the affine point unit: FSM state encoding and the
//   operation-mode constants.
package ecc_point_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NUMDEN,
    S_INV,
    S_LAMBDA,
    S_XOUT,
    S_YOUT,
    S_DONE
  } state_e;

  localparam logic MODE_DBL = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/ecc_point_unit_mod_inverse.sv
// mod_inverse
//   Modular inverse over GF(p), p odd, by binary extended Euclid.
//   Invariants: r*den == u and s*den == v (mod p). Each step halves the even
//   one of u/v, or subtracts the smaller odd from the larger odd and halves
//   the difference, so log2(u*v) shrinks by at least one bit per cycle.
//   Ports:
//     clk, reset   clock, async active-high reset
//     start        load den/p and begin (ignored while running)
//     p, den       modulus and value to invert (den != 0, den < p)
//     done         one-cycle pulse, inv valid and held until next start
//     inv          den^-1 mod p
module mod_inverse #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] den,
  output logic         done,
  output logic [n-1:0] inv
);

  logic         run_q, run_d, done_q, done_d;
  logic [n-1:0] u_q, u_d, v_q, v_d, r_q, r_d, s_q, s_d, inv_q, inv_d;

  function automatic logic [n-1:0] msub(input logic [n-1:0] x, y, m);
    logic [n:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (x < y) t = t + {1'b0, m};
    return t[n-1:0];
  endfunction

  // x/2 mod p: odd values become even by adding p first.
  function automatic logic [n-1:0] mhalf(input logic [n-1:0] x, m);
    logic [n:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return t[n:1];
  endfunction

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    u_d    = u_q;
    v_d    = v_q;
    r_d    = r_q;
    s_d    = s_q;
    inv_d  = inv_q;
    if (!run_q) begin
      if (start) begin
        u_d   = den;
        v_d   = p;
        r_d   = n'(1);
        s_d   = '0;
        run_d = 1'b1;
      end
    end else if (u_q == n'(1)) begin
      inv_d  = r_q;
      done_d = 1'b1;
      run_d  = 1'b0;
    end else if (v_q == n'(1)) begin
      inv_d  = s_q;
      done_d = 1'b1;
      run_d  = 1'b0;
    end else if (!u_q[0]) begin
      u_d = u_q >> 1;
      r_d = mhalf(r_q, p);
    end else if (!v_q[0]) begin
      v_d = v_q >> 1;
      s_d = mhalf(s_q, p);
    end else if (u_q > v_q) begin
      u_d = (u_q - v_q) >> 1;
      r_d = mhalf(msub(r_q, s_q, p), p);
    end else begin
      v_d = (v_q - u_q) >> 1;
      s_d = mhalf(msub(s_q, r_q, p), p);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      u_q    <= '0;
      v_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      inv_q  <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      u_q    <= u_d;
      v_q    <= v_d;
      r_q    <= r_d;
      s_q    <= s_d;
      inv_q  <= inv_d;
    end
  end

  assign done = done_q;
  assign inv  = inv_q;

endmodule

// File: rtl/ecc_point_unit.sv
// ecc_point_unit
//   Affine point add/double over GF(p) on Y^2 = X^3 + aX + b. One serial
//   MSB-first shift-add-reduce multiplier (n+1 cycles per product) is shared
//   by the doubling numerator, lambda, x3 and y3 steps; the inverse comes from
//   mod_inverse.
//   Ports:
//     clk, reset          clock, async active-high reset
//     start               request, sampled only in IDLE
//     mode                0 = 2*P1, 1 = P1+P2
//     p, a                field prime, curve coefficient (a < p)
//     x1,y1,x2,y2         operand points, captured on accepted start
//     x3,y3               result, updated when the pulse appears
//     busy                operation in flight
//     result / infinity   one-cycle completion pulses
//   Optional macro ECC_INF_INPUT_EN adds inf1/inf2 inputs flagging operands
//   as the point at infinity; those cases finish straight from CHECK.
module ecc_point_unit
  import ecc_point_unit_pkg::*;
#(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
`ifdef ECC_INF_INPUT_EN
  input  logic         inf1,
  input  logic         inf2,
`endif
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         busy,
  output logic         result,
  output logic         infinity
);

  localparam int CW = $clog2(n + 1) + 1;

  state_e       state_q, state_d;
  logic         mode_q, mode_d, dbl_q, dbl_d, inf_q, inf_d;
  logic [n-1:0] p_q, p_d, a_q, a_d, x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [n-1:0] num_q, num_d, lam_q, lam_d, xr_q, xr_d, x3_q, x3_d, y3_q, y3_d;
  logic [n-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef ECC_INF_INPUT_EN
  logic         inf1_q, inf1_d, inf2_q, inf2_d;
`endif

  logic [n-1:0] mul_a, mul_b, mb_sh, acc_in, acc_dbl, acc_step;
  logic         mul_done, in_mul;
  logic [n-1:0] inv_den, inv_res;
  logic         inv_start, inv_done;

  function automatic logic [n-1:0] madd(input logic [n-1:0] x, y, m);
    logic [n:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[n-1:0];
  endfunction

  function automatic logic [n-1:0] msub(input logic [n-1:0] x, y, m);
    logic [n:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (x < y) t = t + {1'b0, m};
    return t[n-1:0];
  endfunction

  // Multiplier operand select; product = mul_a * mul_b, bits of mul_b scanned.
  always_comb begin
    mul_a = lam_q;
    mul_b = lam_q;
    unique case (state_q)
      S_NUMDEN: begin mul_a = x1_q;                    mul_b = x1_q;    end
      S_LAMBDA: begin mul_a = num_q;                   mul_b = inv_res; end
      S_YOUT:   begin mul_a = msub(x1_q, xr_q, p_q);   mul_b = lam_q;   end
      default: ;
    endcase
  end

  // cnt 0..n-1 consume bits n-1..0; cnt == n is the hand-off cycle.
  assign mul_done = (cnt_q == CW'(n));
  assign mb_sh    = mul_b << cnt_q;
  assign acc_in   = (cnt_q == '0) ? '0 : acc_q;
  assign acc_dbl  = madd(acc_in, acc_in, p_q);
  assign acc_step = mb_sh[n-1] ? madd(acc_dbl, mul_a, p_q) : acc_dbl;
  assign in_mul   = (state_q == S_LAMBDA) || (state_q == S_XOUT) ||
                    (state_q == S_YOUT) || ((state_q == S_NUMDEN) && dbl_q);
  assign inv_den  = dbl_q ? madd(y1_q, y1_q, p_q) : msub(x2_q, x1_q, p_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dbl_d     = dbl_q;
    inf_d     = inf_q;
    p_d       = p_q;
    a_d       = a_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    x2_d      = x2_q;
    y2_d      = y2_q;
    num_d     = num_q;
    lam_d     = lam_q;
    xr_d      = xr_q;
    x3_d      = x3_q;
    y3_d      = y3_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    inv_start = 1'b0;
`ifdef ECC_INF_INPUT_EN
    inf1_d    = inf1_q;
    inf2_d    = inf2_q;
`endif

    if (in_mul) begin
      if (mul_done) cnt_d = '0;
      else begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: if (start) begin
        mode_d  = mode;
        p_d     = p;
        a_d     = a;
        x1_d    = x1;
        y1_d    = y1;
        x2_d    = x2;
        y2_d    = y2;
        inf_d   = 1'b0;
        cnt_d   = '0;
`ifdef ECC_INF_INPUT_EN
        inf1_d  = inf1;
        inf2_d  = inf2;
`endif
        state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef ECC_INF_INPUT_EN
        if (inf1_q && (inf2_q || mode_q == MODE_DBL)) begin
          inf_d = 1'b1; x3_d = '0; y3_d = '0; state_d = S_DONE;
        end else if (inf1_q || (inf2_q && mode_q == MODE_ADD)) begin
          x3_d    = inf1_q ? x2_q : x1_q;
          y3_d    = inf1_q ? y2_q : y1_q;
          state_d = S_DONE;
        end else
`endif
        // P + (-P), or doubling a point with y == 0, is the point at infinity.
        if ((mode_q == MODE_ADD && x1_q == x2_q && y1_q != y2_q) ||
            ((mode_q == MODE_DBL || x1_q == x2_q) && y1_q == '0)) begin
          inf_d = 1'b1; x3_d = '0; y3_d = '0; state_d = S_DONE;
        end else begin
          // Equal points reaching here in add mode are doubled; x2 := x1
          // lets XOUT use one formula for both paths.
          dbl_d   = (mode_q == MODE_DBL) || (x1_q == x2_q);
          x2_d    = ((mode_q == MODE_DBL) || (x1_q == x2_q)) ? x1_q : x2_q;
          state_d = S_NUMDEN;
        end
      end
      S_NUMDEN: begin
        if (!dbl_q) begin
          num_d     = msub(y2_q, y1_q, p_q);
          inv_start = 1'b1;
          state_d   = S_INV;
        end else if (mul_done) begin
          num_d     = madd(madd(madd(acc_q, acc_q, p_q), acc_q, p_q), a_q, p_q);
          inv_start = 1'b1;
          state_d   = S_INV;
        end
      end
      S_INV:    if (inv_done) state_d = S_LAMBDA;
      S_LAMBDA: if (mul_done) begin lam_d = acc_q; state_d = S_XOUT; end
      S_XOUT:   if (mul_done) begin
        xr_d    = msub(msub(acc_q, x1_q, p_q), x2_q, p_q);
        state_d = S_YOUT;
      end
      S_YOUT:   if (mul_done) begin
        x3_d    = xr_q;
        y3_d    = msub(acc_q, y1_q, p_q);
        state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_DBL;
      dbl_q   <= 1'b0;
      inf_q   <= 1'b0;
      p_q     <= '0;
      a_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      num_q   <= '0;
      lam_q   <= '0;
      xr_q    <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef ECC_INF_INPUT_EN
      inf1_q  <= 1'b0;
      inf2_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dbl_q   <= dbl_d;
      inf_q   <= inf_d;
      p_q     <= p_d;
      a_q     <= a_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      num_q   <= num_d;
      lam_q   <= lam_d;
      xr_q    <= xr_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef ECC_INF_INPUT_EN
      inf1_q  <= inf1_d;
      inf2_q  <= inf2_d;
`endif
    end
  end

  mod_inverse #(.n(n)) u_inv (
    .clk   (clk),
    .reset (reset),
    .start (inv_start),
    .p     (p_q),
    .den   (inv_den),
    .done  (inv_done),
    .inv   (inv_res)
  );

  // Outputs decode straight from registered state: the DONE cycle carries
  // the pulse and is already outside the busy window.
  assign x3       = x3_q;
  assign y3       = y3_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign result   = (state_q == S_DONE) && !inf_q;
  assign infinity = (state_q == S_DONE) && inf_q;

endmodule

// File: tb/tb_ecc_point_unit.sv
module tb_ecc_point_unit;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset, start, mode;
  logic [N-1:0] p, a, x1, y1, x2, y2, x3, y3;
  logic         busy, result, infinity;
`ifdef ECC_INF_INPUT_EN
  logic         inf1, inf2;
`endif

  int checks = 0;
  int failures = 0;
  int primes[5] = '{17, 101, 509, 1009, 1021};

  always #5 clk = ~clk;

  ecc_point_unit #(.n(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .p        (p),
    .a        (a),
    .x1       (x1),
    .y1       (y1),
    .x2       (x2),
    .y2       (y2),
`ifdef ECC_INF_INPUT_EN
    .inf1     (inf1),
    .inf2     (inf2),
`endif
    .x3       (x3),
    .y3       (y3),
    .busy     (busy),
    .result   (result),
    .infinity (infinity)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int powmod(input int b, input int e, input int m);
    longint r, x;
    int k;
    r = 1; x = b; k = e;
    while (k > 0) begin
      if (k % 2 == 1) r = (r * x) % m;
      x = (x * x) % m;
      k = k / 2;
    end
    return int'(r);
  endfunction

  // Textbook affine group law; inverse by Fermat's little theorem.
  function automatic void ref_pt(input int pp, aa, m, xa, ya, xb, yb, i1, i2,
                                 output int rx, output int ry, output bit rinf);
    int num, den, lam, xo;
    bit dbl;
    rx = 0; ry = 0; rinf = 0;
    if (i1 != 0 && (i2 != 0 || m == 0)) begin rinf = 1; return; end
    if (i1 != 0) begin rx = xb; ry = yb; return; end
    if (i2 != 0 && m == 1) begin rx = xa; ry = ya; return; end
    if (m == 1 && xa == xb && ya != yb) begin rinf = 1; return; end
    dbl = (m == 0) || (xa == xb && ya == yb);
    if (dbl && ya == 0) begin rinf = 1; return; end
    if (dbl) begin
      num = (3 * xa * xa + aa) % pp;
      den = (2 * ya) % pp;
      xo  = xa;
    end else begin
      num = (yb - ya + pp) % pp;
      den = (xb - xa + pp) % pp;
      xo  = xb;
    end
    lam = (num * powmod(den, pp - 2, pp)) % pp;
    rx  = ((lam * lam) % pp + 2 * pp - xa - xo) % pp;
    ry  = ((lam * ((xa - rx + pp) % pp)) % pp + pp - ya) % pp;
  endfunction

  task automatic run_op(input string tag, input int pp, aa, m, xa, ya, xb, yb,
                        input int i1, i2, input bit poke);
    int ex, ey, pulses;
    bit einf, got;
    ref_pt(pp, aa, m, xa, ya, xb, yb, i1, i2, ex, ey, einf);
    @(negedge clk);
    p = N'(pp); a = N'(aa); mode = m[0];
    x1 = N'(xa); y1 = N'(ya); x2 = N'(xb); y2 = N'(yb);
`ifdef ECC_INF_INPUT_EN
    inf1 = i1[0]; inf2 = i2[0];
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // operands must have been captured; scramble the live inputs
    x1 = N'($urandom); y1 = N'($urandom); x2 = N'($urandom); y2 = N'($urandom);
    a = N'($urandom); mode = ~mode;
    check({tag, " busy_after_start"}, busy, 1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (result || infinity) got = 1;
      else @(negedge clk);
    end
    check({tag, " completion"}, got, 1);
    check({tag, " result"}, result, !einf);
    check({tag, " infinity"}, infinity, einf);
    check({tag, " x3"}, x3, ex);
    check({tag, " y3"}, y3, ey);
    check({tag, " busy_at_pulse"}, busy, 0);
    @(negedge clk);
    check({tag, " pulse_one_cycle"}, result | infinity, 0);
    if (poke) begin
      pulses = 0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        if (result || infinity) pulses++;
      end
      check({tag, " no_queued_op"}, pulses, 0);
    end
  endtask

  initial begin
    int pp, aa, m, xa, ya, xb, yb, pulses;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    p = '0; a = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
`ifdef ECC_INF_INPUT_EN
    inf1 = 1'b0; inf2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset x3", x3, 0);
    check("reset y3", y3, 0);
    check("reset busy", busy, 0);
    check("reset pulses", result | infinity, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    run_op("s1_dbl",       17, 2, 0, 5, 1, 0, 0,  0, 0, 0);
    run_op("s2_add",       17, 2, 1, 6, 3, 5, 1,  0, 0, 0);
    run_op("s3_neg",       17, 2, 1, 5, 1, 5, 16, 0, 0, 0);
    run_op("s4_eq",        17, 2, 1, 5, 1, 5, 1,  0, 0, 0);
    run_op("s5_dbl_poke",  17, 2, 0, 6, 3, 0, 0,  0, 0, 1);

    // abort in the inverse phase, leaving nonzero previous outputs
    @(negedge clk);
    p = 10'd17; a = 10'd2; mode = 1'b0; x1 = 10'd5; y1 = 10'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("s6 reset x3", x3, 0);
    check("s6 reset y3", y3, 0);
    check("s6 reset busy", busy, 0);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (result || infinity) pulses++;
    end
    check("s6 no_pulse", pulses, 0);
    check("s6 idle busy", busy, 0);
    run_op("s6_after", 17, 2, 0, 5, 1, 0, 0, 0, 0, 0);

`ifdef ECC_INF_INPUT_EN
    run_op("inf1_add",  17, 2, 1, 9, 9, 5, 1, 1, 0, 0);
    run_op("inf2_add",  17, 2, 1, 6, 3, 9, 9, 0, 1, 0);
    run_op("inf_both",  17, 2, 1, 6, 3, 5, 1, 1, 1, 0);
    run_op("inf1_dbl",  17, 2, 0, 6, 3, 0, 0, 1, 0, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      pp = primes[$urandom_range(0, 4)];
      aa = int'($urandom_range(0, pp - 1));
      m  = int'($urandom_range(0, 1));
      xa = int'($urandom_range(0, pp - 1));
      ya = int'($urandom_range(0, pp - 1));
      xb = int'($urandom_range(0, pp - 1));
      yb = int'($urandom_range(0, pp - 1));
      case ($urandom_range(0, 5))
        0: begin xb = xa; yb = ya; end
        1: begin xb = xa; yb = (pp - ya) % pp; end
        2: ya = 0;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", k), pp, aa, m, xa, ya, xb, yb, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
